memory_access_stage: RTL

Fourth pipeline stage of the 5-stage ARM core: consumes the execute-stage result bundle, holds it in the EX/MEM register, performs the load or store against a variable-latency data memory over a req/ack handshake, and presents the registered MEM/WB bundle to writeback. It stalls the front of the pipeline while an access is outstanding and aborts accesses that exceed a wait budget.

---
 rtl/pipeline_pkg.sv | 39 +++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/memory_access_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types for the memory-access stage of the 5-stage ARM core.
//   mem_state_t : MEM-stage sequencer states (IDLE, ACCESS)
//   exmem_t     : control half of the EX/MEM register (bubble-masked)
//   memwb_t     : control half of the MEM/WB register
//   XZR         : register index of the zero register (never forwarded)
// The DATA_W-wide datapath fields live beside these structs in the stage, so
// that the structs do not depend on the stage's width parameter.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } exmem_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       mem_to_reg;
        logic       reg_write;
    } memwb_t;

    // Control bits are already forced to 0 for bubbles on capture, so a
    // memory operation is simply any bundle that reads or writes memory.
    function automatic logic is_mem_op(input exmem_t b);
        return b.mem_write | b.mem_to_reg;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles an outstanding data-memory access has waited for its ack.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count (new access begins next cycle)
//   enable     : count this cycle (access outstanding, no ack)
//   expired    : the current cycle is the TIMEOUT-th waiting cycle
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // count is 0 in the first cycle of an access, so the TIMEOUT-th cycle is
    // the one that sees count == TIMEOUT-1.
    assign expired = (count == CW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// MEM stage of the 5-stage ARM core. Holds the EX/MEM register, performs the
// load/store over a req/ack data-memory handshake, aborts accesses that wait
// TIMEOUT cycles without ack, and drives the MEM/WB register.
//   clk, reset          : clock, asynchronous active-high reset
//   *_EX                : execute-stage bundle (valid_EX=0 is a bubble)
//   stall_MEM           : upstream must hold its bundle this cycle
//   dmem_*              : data-memory request/ack interface
//   *_MEM               : registered MEM/WB bundle for writeback
//   mem_error           : sticky, an access timed out (cleared by reset only)
// Optional macro MEM_FORWARD_EN adds fwd_valid_MEM / fwd_Rd_MEM /
// fwd_data_MEM, a combinational forwarding view of the MEM/WB register.
// -----------------------------------------------------------------------------
module memory_access_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_EX,
    input  logic [DATA_W-1:0] ALUResult_EX,
    input  logic [DATA_W-1:0] RdData2_EX,
    input  logic [DATA_W-1:0] WrData_EX,
    input  logic [4:0]        Rd_EX,
    input  logic              MemWrite_EX,
    input  logic              MemToReg_EX,
    input  logic              RegWrite_EX,
    output logic              stall_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] ALUResult_MEM,
    output logic [DATA_W-1:0] MemData_MEM,
    output logic [DATA_W-1:0] WrData_MEM,
    output logic [4:0]        Rd_MEM,
    output logic              RegWrite_MEM,
    output logic              MemToReg_MEM,
`ifdef MEM_FORWARD_EN
    output logic              fwd_valid_MEM,
    output logic [4:0]        fwd_Rd_MEM,
    output logic [DATA_W-1:0] fwd_data_MEM,
`endif
    output logic              mem_error
);

    mem_state_t        state, state_next;
    exmem_t            ex_ctrl, exmem_ctrl;
    logic [DATA_W-1:0] exmem_alu, exmem_rd2, exmem_wr;
    memwb_t            memwb_ctrl;
    logic [DATA_W-1:0] memwb_alu, memwb_mem, memwb_wr;
    logic              advance, timed_out, expired;

    // Bubbles are neutralised on entry so nothing downstream re-checks valid.
    always_comb begin
        ex_ctrl.rd         = Rd_EX;
        ex_ctrl.mem_write  = valid_EX & MemWrite_EX;
        ex_ctrl.mem_to_reg = valid_EX & MemToReg_EX;
        ex_ctrl.reg_write  = valid_EX & RegWrite_EX;
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        timed_out  = 1'b0;
        stall_MEM  = 1'b0;
        dmem_req   = 1'b0;
        case (state)
            IDLE: begin
                advance = 1'b1;
            end
            ACCESS: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    advance = 1'b1;
                end else if (expired) begin
                    // Abort edge: the EX/MEM register takes the next bundle,
                    // so upstream must be released in this cycle too.
                    advance   = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    stall_MEM = 1'b1;
                end
            end
            default: ;
        endcase
        if (advance) begin
            state_next = is_mem_op(ex_ctrl) ? ACCESS : IDLE;
        end
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (advance),
        .enable  (dmem_req && !dmem_ack),
        .expired (expired)
    );

    // Request fields are gated so the bus reads 0 whenever no access is live.
    assign dmem_we    = dmem_req & exmem_ctrl.mem_write;
    assign dmem_addr  = dmem_req ? exmem_alu : '0;
    assign dmem_wdata = dmem_req ? exmem_rd2 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // EX/MEM register: advances exactly when stall_MEM is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_ctrl <= '0;
            exmem_alu  <= '0;
            exmem_rd2  <= '0;
            exmem_wr   <= '0;
        end else if (advance) begin
            exmem_ctrl <= ex_ctrl;
            exmem_alu  <= ALUResult_EX;
            exmem_rd2  <= RdData2_EX;
            exmem_wr   <= WrData_EX;
        end
    end

    // MEM/WB register plus the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb_ctrl <= '0;
            memwb_alu  <= '0;
            memwb_mem  <= '0;
            memwb_wr   <= '0;
            mem_error  <= 1'b0;
        end else if (advance) begin
            if (timed_out) begin
                memwb_ctrl <= '0;
                memwb_alu  <= '0;
                memwb_mem  <= '0;
                memwb_wr   <= '0;
                mem_error  <= 1'b1;
            end else begin
                memwb_ctrl.rd         <= exmem_ctrl.rd;
                memwb_ctrl.mem_to_reg <= exmem_ctrl.mem_to_reg;
                memwb_ctrl.reg_write  <= exmem_ctrl.reg_write;
                memwb_alu             <= exmem_alu;
                memwb_wr              <= exmem_wr;
                memwb_mem             <= (dmem_req && !exmem_ctrl.mem_write)
                                         ? dmem_rdata : '0;
            end
        end
    end

    assign ALUResult_MEM = memwb_alu;
    assign MemData_MEM   = memwb_mem;
    assign WrData_MEM    = memwb_wr;
    assign Rd_MEM        = memwb_ctrl.rd;
    assign RegWrite_MEM  = memwb_ctrl.reg_write;
    assign MemToReg_MEM  = memwb_ctrl.mem_to_reg;

`ifdef MEM_FORWARD_EN
    // Writes to the zero register are architecturally discarded, never forwarded.
    assign fwd_valid_MEM = memwb_ctrl.reg_write && (memwb_ctrl.rd != XZR);
    assign fwd_Rd_MEM    = memwb_ctrl.rd;
    assign fwd_data_MEM  = memwb_ctrl.mem_to_reg ? memwb_mem : memwb_alu;
`endif

endmodule
